// File: rtl/branch_flag_unit_if.sv
// EX-stage <-> branch/flag unit bundle: instruction-side inputs, flag and redirect outputs.
// Latency: none (wires only).
// Backpressure: stall travels with the bundle; the unit freezes on it.
// Ports (slave view): stall, ex_* instruction fields, alu_* status, cbz_zero in;
//                     flags_q, br_taken, br_target_q, squash out.
interface branch_flag_unit_if #(
    parameter int ADDR_W = 64
);
    logic              stall;
    logic              ex_valid;
    logic              ex_set_flags;
    logic              alu_neg;
    logic              alu_zero;
    logic              alu_carry;
    logic              alu_ovf;
    logic              cbz_zero;
    logic [1:0]        ex_br_type;
    logic [3:0]        ex_cond;
    logic [ADDR_W-1:0] ex_br_target;

    logic [3:0]        flags_q;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target_q;
    logic              squash;

    // Pipeline side: presents the EX instruction and observes the redirect.
    modport master (
        output stall, ex_valid, ex_set_flags, alu_neg, alu_zero, alu_carry,
               alu_ovf, cbz_zero, ex_br_type, ex_cond, ex_br_target,
        input  flags_q, br_taken, br_target_q, squash
    );

    // Branch/flag unit side.
    modport slave (
        input  stall, ex_valid, ex_set_flags, alu_neg, alu_zero, alu_carry,
               alu_ovf, cbz_zero, ex_br_type, ex_cond, ex_br_target,
        output flags_q, br_taken, br_target_q, squash
    );
endinterface

// File: rtl/branch_flag_unit.sv
// Registers NZCV on flag-setting ops and resolves B / CBZ / B.cond in EX.
// Latency: taken branch in cycle t -> br_taken pulse + br_target_q in t+1; squash for SQUASH_CYCLES.
// Backpressure: stall freezes flags, target and squash counter; a stalled branch resolves once stall drops.
// Ports: clk, reset (sync, active-high), bus (branch_flag_unit_if.slave).
module branch_flag_unit #(
    parameter int ADDR_W        = 64,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    branch_flag_unit_if.slave  bus
);
    localparam int CNT_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SQUASH_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_SQUASH
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              squash_q;
    logic              br_taken_q;
    logic [3:0]        nzcv_q;
    logic [3:0]        nzcv_d;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] target_d;

    logic              eff_valid;
    logic              cond_met;
    logic              taken;
    logic              fire;

    // Condition evaluation against the flags registered at the end of the
    // previous cycle, so a flag-setting op and a B.cond in the same cycle
    // see the older flags.
    always_comb begin
        logic n, z, c, v, ge, gt;
        n  = nzcv_q[3];
        z  = nzcv_q[2];
        c  = nzcv_q[1];
        v  = nzcv_q[0];
        ge = (n == v);
        gt = ~z & ge;
        cond_met = 1'b0;
        case (bus.ex_cond)
            4'h0: cond_met = z;
            4'h1: cond_met = ~z;
            4'h2: cond_met = c;
            4'h3: cond_met = ~c;
            4'h4: cond_met = n;
            4'h5: cond_met = ~n;
            4'h6: cond_met = v;
            4'h7: cond_met = ~v;
            4'h8: cond_met = c & ~z;
            4'h9: cond_met = ~(c & ~z);
            4'hA: cond_met = ge;
            4'hB: cond_met = ~ge;
            4'hC: cond_met = gt;
            4'hD: cond_met = ~gt;
            default: cond_met = 1'b1;
        endcase
    end

    always_comb begin
        // Wrong-path (squashed) and held instructions have no architectural effect.
        eff_valid = bus.ex_valid & ~squash_q & ~bus.stall;

        taken = 1'b0;
        case (bus.ex_br_type)
            2'b01:   taken = 1'b1;
            2'b10:   taken = bus.cbz_zero;
            2'b11:   taken = cond_met;
            default: taken = 1'b0;
        endcase
        fire = eff_valid & taken;

        nzcv_d = nzcv_q;
        if (eff_valid && bus.ex_set_flags) begin
            nzcv_d = {bus.alu_neg, bus.alu_zero, bus.alu_carry, bus.alu_ovf};
        end

        target_d = target_q;
        if (fire) begin
            target_d = bus.ex_br_target;
        end
    end

    // br_taken is the only state not frozen by stall; because a taken branch
    // immediately enters SQUASH (which blocks eff_valid), it can never pulse
    // on two consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            squash_q   <= 1'b0;
            br_taken_q <= 1'b0;
            nzcv_q     <= 4'h0;
            target_q   <= '0;
        end else begin
            nzcv_q     <= nzcv_d;
            target_q   <= target_d;
            br_taken_q <= fire;
            case (state_q)
                S_IDLE: begin
                    if (fire) begin
                        state_q  <= S_SQUASH;
                        cnt_q    <= CNT_INIT;
                        squash_q <= 1'b1;
                    end
                end
                S_SQUASH: begin
                    // Stall stretches the window so the held younger
                    // instructions are still killed when they move on.
                    if (!bus.stall) begin
                        if (cnt_q == '0) begin
                            state_q  <= S_IDLE;
                            squash_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    squash_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flags_q     = nzcv_q;
    assign bus.br_taken    = br_taken_q;
    assign bus.br_target_q = target_q;
    assign bus.squash      = squash_q;
endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: expected redirect targets are queued
// when a taken branch is driven and popped when the pulse is due.
module tb_branch_flag_unit;
    localparam int ADDR_W = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_flag_unit_if #(.ADDR_W(ADDR_W)) bif ();

    branch_flag_unit #(
        .ADDR_W        (ADDR_W),
        .SQUASH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_q [$];
    logic [ADDR_W-1:0] exp_t;
    logic [ADDR_W-1:0] last_tgt;
    logic [3:0]        exp_flags;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sf, input logic [3:0] nzcv,
                         input logic cz, input logic [1:0] bt, input logic [3:0] cond,
                         input logic [ADDR_W-1:0] tgt);
        bif.ex_valid     = v;
        bif.ex_set_flags = sf;
        bif.alu_neg      = nzcv[3];
        bif.alu_zero     = nzcv[2];
        bif.alu_carry    = nzcv[1];
        bif.alu_ovf      = nzcv[0];
        bif.cbz_zero     = cz;
        bif.ex_br_type   = bt;
        bif.ex_cond      = cond;
        bif.ex_br_target = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 4'h0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.stall = 1'b0;
        idle();
        tick(); tick();
        n_cmp++; if (bif.flags_q !== 4'h0) begin n_err++; $display("FAIL rst0_flags: got %h want 0", bif.flags_q); end
        n_cmp++; if (bif.br_taken !== 1'b0) begin n_err++; $display("FAIL rst0_br_taken: got %b want 0", bif.br_taken); end
        n_cmp++; if (bif.br_target_q !== '0) begin n_err++; $display("FAIL rst0_target: got %h want 0", bif.br_target_q); end
        n_cmp++; if (bif.squash !== 1'b0) begin n_err++; $display("FAIL rst0_squash: got %b want 0", bif.squash); end
        reset = 1'b0;
        // Taken B that also sets flags, then reset in the middle of its squash window.
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'b01, 4'h0, 64'h123);
        exp_q.push_back(64'h123);
        tick();
        exp_t = exp_q.pop_front();
        n_cmp++; if (bif.br_taken !== 1'b1) begin n_err++; $display("FAIL rst_pre_pulse: got %b want 1", bif.br_taken); end
        n_cmp++; if (bif.br_target_q !== exp_t) begin n_err++; $display("FAIL rst_pre_target: got %h want %h", bif.br_target_q, exp_t); end
        n_cmp++; if (bif.squash !== 1'b1) begin n_err++; $display("FAIL rst_pre_squash: got %b want 1", bif.squash); end
        idle();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (bif.flags_q !== 4'h0) begin n_err++; $display("FAIL rst1_flags: got %h want 0", bif.flags_q); end
        n_cmp++; if (bif.br_taken !== 1'b0) begin n_err++; $display("FAIL rst1_br_taken: got %b want 0", bif.br_taken); end
        n_cmp++; if (bif.br_target_q !== '0) begin n_err++; $display("FAIL rst1_target: got %h want 0", bif.br_target_q); end
        n_cmp++; if (bif.squash !== 1'b0) begin n_err++; $display("FAIL rst1_squash: got %b want 0", bif.squash); end
        reset = 1'b0;
        tick();
        n_cmp++; if (bif.squash !== 1'b0) begin n_err++; $display("FAIL rst_after_squash: got %b want 0", bif.squash); end
        exp_flags = 4'h0;
        last_tgt  = '0;
    endtask

    task automatic test_subs_beq();
        drive(1'b1, 1'b1, 4'b0110, 1'b0, 2'b00, 4'h0, '0);
        exp_flags = 4'b0110;
        tick();
        n_cmp++; if (bif.flags_q !== exp_flags) begin n_err++; $display("FAIL subs_flags: got %h want %h", bif.flags_q, exp_flags); end
        n_cmp++; if (bif.br_taken !== 1'b0) begin n_err++; $display("FAIL subs_no_pulse: got %b want 0", bif.br_taken); end
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'b11, 4'h0, 64'h40);
        exp_q.push_back(64'h40);
        tick();
        exp_t = exp_q.pop_front();
        last_tgt = exp_t;
        n_cmp++; if (bif.br_taken !== 1'b1) begin n_err++; $display("FAIL beq_pulse: got %b want 1", bif.br_taken); end
        n_cmp++; if (bif.br_target_q !== exp_t) begin n_err++; $display("FAIL beq_target: got %h want %h", bif.br_target_q, exp_t); end
        n_cmp++; if (bif.squash !== 1'b1) begin n_err++; $display("FAIL beq_squash1: got %b want 1", bif.squash); end
        idle();
        tick();
        n_cmp++; if (bif.br_taken !== 1'b0) begin n_err++; $display("FAIL beq_single_pulse: got %b want 0", bif.br_taken); end
        n_cmp++; if (bif.squash !== 1'b1) begin n_err++; $display("FAIL beq_squash2: got %b want 1", bif.squash); end
        n_cmp++; if (bif.br_target_q !== last_tgt) begin n_err++; $display("FAIL beq_target_hold: got %h want %h", bif.br_target_q, last_tgt); end
        tick();
        n_cmp++; if (bif.squash !== 1'b0) begin n_err++; $display("FAIL beq_squash_end: got %b want 0", bif.squash); end
    endtask

    task automatic test_cbz();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'b10, 4'h0, 64'h80);
        tick();
        n_cmp++; if (bif.br_taken !== 1'b0) begin n_err++; $display("FAIL cbz_nz_pulse: got %b want 0", bif.br_taken); end
        n_cmp++; if (bif.squash !== 1'b0) begin n_err++; $display("FAIL cbz_nz_squash: got %b want 0", bif.squash); end
        n_cmp++; if (bif.br_target_q !== last_tgt) begin n_err++; $display("FAIL cbz_nz_target: got %h want %h", bif.br_target_q, last_tgt); end
        drive(1'b1, 1'b0, 4'h0, 1'b1, 2'b10, 4'h0, 64'h88);
        exp_q.push_back(64'h88);
        tick();
        exp_t = exp_q.pop_front();
        last_tgt = exp_t;
        n_cmp++; if (bif.br_taken !== 1'b1) begin n_err++; $display("FAIL cbz_z_pulse: got %b want 1", bif.br_taken); end
        n_cmp++; if (bif.br_target_q !== exp_t) begin n_err++; $display("FAIL cbz_z_target: got %h want %h", bif.br_target_q, exp_t); end
        idle();
        tick(); tick();
    endtask

    task automatic test_bcond();
        // Expected taken mask per condition code 0..F for each flag pattern {N,Z,C,V}.
        logic [3:0]  pats  [3] = '{4'h8, 4'h3, 4'h4};
        logic [15:0] masks [3] = '{16'hEA9A, 16'hE966, 16'hE6A9};
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 1'b1, pats[p], 1'b0, 2'b00, 4'h0, '0);
            exp_flags = pats[p];
            tick();
            n_cmp++; if (bif.flags_q !== exp_flags) begin n_err++; $display("FAIL bcond_flags p%0d: got %h want %h", p, bif.flags_q, exp_flags); end
            for (int c = 0; c < 16; c++) begin
                logic [15:0] m;
                logic        exp_tk;
                m = masks[p];
                exp_tk = m[c];
                drive(1'b1, 1'b0, 4'h0, 1'b0, 2'b11, 4'(c), 64'h1000 + 64'(p * 16 + c));
                if (exp_tk) exp_q.push_back(64'h1000 + 64'(p * 16 + c));
                tick();
                n_cmp++; if (bif.br_taken !== exp_tk) begin n_err++; $display("FAIL bcond p%0d c%h: br_taken got %b want %b", p, c, bif.br_taken, exp_tk); end
                if (exp_tk) begin
                    exp_t = exp_q.pop_front();
                    last_tgt = exp_t;
                end
                n_cmp++; if (bif.br_target_q !== last_tgt) begin n_err++; $display("FAIL bcond_tgt p%0d c%h: got %h want %h", p, c, bif.br_target_q, last_tgt); end
                idle();
                tick(); tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'b01, 4'h0, 64'h200);
        exp_q.push_back(64'h200);
        tick();
        exp_t = exp_q.pop_front();
        last_tgt = exp_t;
        n_cmp++; if (bif.br_taken !== 1'b1) begin n_err++; $display("FAIL b2b_pulse: got %b want 1", bif.br_taken); end
        n_cmp++; if (bif.br_target_q !== exp_t) begin n_err++; $display("FAIL b2b_target: got %h want %h", bif.br_target_q, exp_t); end
        // ADDS + B on the wrong path: both must be ignored.
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'b01, 4'h0, 64'h300);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (bif.br_taken !== 1'b0) begin n_err++; $display("FAIL b2b_ignored_pulse %0d: got %b want 0", i, bif.br_taken); end
            n_cmp++; if (bif.flags_q !== exp_flags) begin n_err++; $display("FAIL b2b_flags %0d: got %h want %h", i, bif.flags_q, exp_flags); end
            n_cmp++; if (bif.br_target_q !== last_tgt) begin n_err++; $display("FAIL b2b_target_hold %0d: got %h want %h", i, bif.br_target_q, last_tgt); end
        end
        idle();
        tick();
        n_cmp++; if (bif.squash !== 1'b0) begin n_err++; $display("FAIL b2b_squash_end: got %b want 0", bif.squash); end
    endtask

    task automatic test_stall();
        bif.stall = 1'b1;
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'b01, 4'h0, 64'h400);
        exp_q.push_back(64'h400);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bif.br_taken !== 1'b0) begin n_err++; $display("FAIL stall_no_pulse %0d: got %b want 0", i, bif.br_taken); end
            n_cmp++; if (bif.squash !== 1'b0) begin n_err++; $display("FAIL stall_no_squash %0d: got %b want 0", i, bif.squash); end
        end
        bif.stall = 1'b0;
        tick();
        exp_t = exp_q.pop_front();
        last_tgt = exp_t;
        n_cmp++; if (bif.br_taken !== 1'b1) begin n_err++; $display("FAIL stall_release_pulse: got %b want 1", bif.br_taken); end
        n_cmp++; if (bif.br_target_q !== exp_t) begin n_err++; $display("FAIL stall_release_target: got %h want %h", bif.br_target_q, exp_t); end
        idle();
        tick();
        n_cmp++; if (bif.br_taken !== 1'b0) begin n_err++; $display("FAIL stall_single_pulse: got %b want 0", bif.br_taken); end
        n_cmp++; if (bif.squash !== 1'b1) begin n_err++; $display("FAIL stall_sq_a: got %b want 1", bif.squash); end
        bif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bif.squash !== 1'b1) begin n_err++; $display("FAIL stall_sq_hold %0d: got %b want 1", i, bif.squash); end
        end
        bif.stall = 1'b0;
        tick();
        n_cmp++; if (bif.squash !== 1'b0) begin n_err++; $display("FAIL stall_sq_end: got %b want 0", bif.squash); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_subs_beq();
        test_cbz();
        test_bcond();
        test_back_to_back();
        test_stall();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
